// File: rtl/vu_meter_pwm_multi.sv
// Multi-channel VU meter: rectify, window-average, optional peak-hold with decay,
// and one double-buffered PWM coil drive per channel sharing a single phase counter.
module vu_meter_pwm_multi #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned PWM_BITS   = 7,
  parameter int unsigned PWM_DIV    = 64,
  parameter int unsigned DECAY_STEP = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         audio_clk_enable,
  input  logic                         audio_enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]   audio_in,
  input  logic                         peak_mode,
  output logic [NUM_CH*PWM_BITS-1:0]   level_out,
  output logic                         level_valid,
  output logic [NUM_CH-1:0]            vu_pwm
);

  localparam int unsigned MAG_W = SAMPLE_W - 1;
  localparam int unsigned ACC_W = SAMPLE_W - 1 + AVG_LOG2;
  localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DIV_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] phase;
  logic [AVG_LOG2-1:0] win_cnt;
  logic [ACC_W-1:0]    acc    [NUM_CH];
  logic [PWM_BITS-1:0] held   [NUM_CH];
  logic [PWM_BITS-1:0] shadow [NUM_CH];
  logic [PWM_BITS-1:0] duty   [NUM_CH];

  logic                tick_c;
  logic                wrap_c;
  logic                accepted_c;
  logic                win_end_c;
  logic [SAMPLE_W-1:0] samp_c  [NUM_CH];
  logic [SAMPLE_W-1:0] neg_c   [NUM_CH];
  logic [MAG_W-1:0]    mag_c   [NUM_CH];
  logic [ACC_W-1:0]    sum_c   [NUM_CH];
  logic [PWM_BITS-1:0] level_c [NUM_CH];
  logic [PWM_BITS-1:0] decay_c [NUM_CH];
  logic [PWM_BITS-1:0] disp_c  [NUM_CH];

  assign tick_c     = (pre_cnt == DIV_W'(PWM_DIV - 1));
  assign wrap_c     = tick_c && (phase == {PWM_BITS{1'b1}});
  assign accepted_c = audio_clk_enable && audio_enable;
  assign win_end_c  = accepted_c && (win_cnt == {AVG_LOG2{1'b1}});

  // Per-channel rectify, running sum, level extraction and peak-hold decay
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      samp_c[c] = audio_in[c*SAMPLE_W +: SAMPLE_W];
      neg_c[c]  = ~samp_c[c] + SAMPLE_W'(1);
      mag_c[c]  = samp_c[c][MAG_W-1:0];
      if (samp_c[c][SAMPLE_W-1]) begin
        // the most negative code has no positive twin; clamp to full scale
        if (samp_c[c][MAG_W-1:0] == '0) mag_c[c] = {MAG_W{1'b1}};
        else                           mag_c[c] = neg_c[c][MAG_W-1:0];
      end
      sum_c[c]   = acc[c] + ACC_W'(mag_c[c]);
      level_c[c] = sum_c[c][ACC_W-1 -: PWM_BITS];
      decay_c[c] = (held[c] > PWM_BITS'(DECAY_STEP)) ? held[c] - PWM_BITS'(DECAY_STEP)
                                                     : '0;
      disp_c[c]  = (peak_mode && (decay_c[c] > level_c[c])) ? decay_c[c] : level_c[c];
    end
  end

  // Free-running PWM timebase; keeps running while audio is disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      phase   <= '0;
    end else begin
      pre_cnt <= tick_c ? '0 : pre_cnt + DIV_W'(1);
      if (tick_c) phase <= phase + PWM_BITS'(1);
    end
  end

  // Averaging, display registers and double-buffered duty
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= '0;
      level_out   <= '0;
      level_valid <= 1'b0;
      vu_pwm      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]    <= '0;
        held[c]   <= '0;
        shadow[c] <= '0;
        duty[c]   <= '0;
      end
    end else if (!audio_enable) begin
      win_cnt     <= '0;
      level_out   <= '0;
      level_valid <= 1'b0;
      vu_pwm      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]    <= '0;
        held[c]   <= '0;
        shadow[c] <= '0;
        duty[c]   <= '0;
      end
    end else begin
      level_valid <= win_end_c;
      if (accepted_c) win_cnt <= win_cnt + AVG_LOG2'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (accepted_c) acc[c] <= win_end_c ? '0 : sum_c[c];
        if (win_end_c) begin
          held[c]                            <= disp_c[c];
          shadow[c]                          <= disp_c[c];
          level_out[c*PWM_BITS +: PWM_BITS]  <= disp_c[c];
        end
        // shadow is sampled before a coincident window-end update lands
        if (wrap_c) duty[c] <= shadow[c];
        vu_pwm[c] <= (phase < duty[c]);
      end
    end
  end

endmodule

// File: tb/tb_vu_meter_pwm_multi.sv
// Scoreboard bench for vu_meter_pwm_multi: default 2-channel instance plus a
// 4-channel fast-PWM instance sharing clock, reset and strobes.
module tb_vu_meter_pwm_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ace, ae, peak_mode;
  logic [31:0] audio_in;
  logic [13:0] level_out;
  logic        level_valid;
  logic [1:0]  vu_pwm;

  logic [63:0] audio_in4;
  logic [27:0] level_out4;
  logic        level_valid4;
  logic [3:0]  vu_pwm4;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [13:0] exp_q[$];
  logic [13:0] mon_exp;
  int          m_sum[2];
  int          m_held[2];
  int          m_cnt;
  int          hi[2];
  int          hi4[4];

  vu_meter_pwm_multi u_dut (
    .clk(clk), .reset(reset), .audio_clk_enable(ace), .audio_enable(ae),
    .audio_in(audio_in), .peak_mode(peak_mode), .level_out(level_out),
    .level_valid(level_valid), .vu_pwm(vu_pwm)
  );

  vu_meter_pwm_multi #(.NUM_CH(4), .PWM_DIV(2)) u_dut4 (
    .clk(clk), .reset(reset), .audio_clk_enable(ace), .audio_enable(ae),
    .audio_in(audio_in4), .peak_mode(peak_mode), .level_out(level_out4),
    .level_valid(level_valid4), .vu_pwm(vu_pwm4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rect(input logic [15:0] x);
    int v;
    v = int'(x);
    if (x == 16'h8000) return 32767;
    if (x[15]) return 65536 - v;
    return v;
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_sum[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  // one strobe, 4 cycles long; the model predicts the window-end level
  task automatic strobe(input logic [15:0] s0, input logic [15:0] s1);
    logic [13:0] e;
    int lvl, d;
    @(negedge clk);
    ace      = 1'b1;
    audio_in = {s1, s0};
    if (ae) begin
      m_sum[0] += rect(s0);
      m_sum[1] += rect(s1);
      m_cnt++;
      if (m_cnt == 16) begin
        e = '0;
        for (int c = 0; c < 2; c++) begin
          lvl = m_sum[c] / 4096;
          if (peak_mode) begin
            d = m_held[c] - 4;
            if (d < 0) d = 0;
            if (d > lvl) lvl = d;
          end
          m_held[c] = lvl;
          e[c*7 +: 7] = 7'(lvl);
          m_sum[c] = 0;
        end
        exp_q.push_back(e);
        m_cnt = 0;
      end
    end
    @(negedge clk);
    ace = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic window(input logic [15:0] s0, input logic [15:0] s1);
    for (int i = 0; i < 16; i++) strobe(s0, s1);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic measure(input int cycles);
    for (int c = 0; c < 2; c++) hi[c] = 0;
    for (int c = 0; c < 4; c++) hi4[c] = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) hi[c] += int'(vu_pwm[c]);
      for (int c = 0; c < 4; c++) hi4[c] += int'(vu_pwm4[c]);
    end
  endtask

  // Scoreboard monitor: every level_valid must match the next predicted window
  always @(negedge clk) begin
    if (level_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("level_out", 32'(level_out), 32'(mon_exp));
      end
    end
  end

  initial begin
    int i;
    reset     = 1'b1;
    ace       = 1'b0;
    ae        = 1'b1;
    peak_mode = 1'b0;
    audio_in  = '0;
    audio_in4 = {16'h7FFF, 16'hE000, 16'h2000, 16'h0000};
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_level", 32'(level_out), 32'd0);
    check("rst_valid", 32'(level_valid), 32'd0);
    check("rst_pwm", 32'(vu_pwm), 32'd0);
    check("rst_pwm4", 32'(vu_pwm4), 32'd0);
    reset = 1'b0;

    // reset mid-window discards the partial sum
    for (int k = 0; k < 7; k++) strobe(16'h4000, 16'h4000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("midrst_level", 32'(level_out), 32'd0);
    check("midrst_valid", 32'(level_valid), 32'd0);
    check("midrst_pwm", 32'(vu_pwm), 32'd0);
    window(16'h4000, 16'h4000);
    wait_drain();

    // full scale, then duty over one whole PWM period
    window(16'h7FFF, 16'h7FFF);
    wait_drain();
    repeat (8200) @(negedge clk);
    measure(8192);
    check("duty_fs_ch0", 32'(hi[0]), 32'd8128);
    check("duty_fs_ch1", 32'(hi[1]), 32'd8128);

    // enable drop mid-window
    for (int k = 0; k < 10; k++) strobe(16'h7FFF, 16'h7FFF);
    i = 0;
    while (!vu_pwm[0] && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("pwm_before_drop", 32'(vu_pwm[0]), 32'd1);
    ae = 1'b0;
    @(negedge clk);
    model_clear();
    check("drop_pwm", 32'(vu_pwm), 32'd0);
    check("drop_level", 32'(level_out), 32'd0);
    check("drop_valid", 32'(level_valid), 32'd0);
    strobe(16'h7FFF, 16'h7FFF);
    ae = 1'b1;
    for (int k = 0; k < 15; k++) strobe(16'h7FFF, 16'h7FFF);
    check("reenable_pwm", 32'(vu_pwm), 32'd0);
    strobe(16'h7FFF, 16'h7FFF);
    wait_drain();

    // rectification including the saturating code
    window(16'h8000, 16'hC000);
    wait_drain();

    // peak-hold decay, then average mode with the same stimulus
    peak_mode = 1'b1;
    window(16'h7FFF, 16'h7FFF);
    for (int w = 0; w < 34; w++) window(16'h0000, 16'h0000);
    wait_drain();
    peak_mode = 1'b0;
    window(16'h7FFF, 16'h7FFF);
    window(16'h0000, 16'h0000);
    wait_drain();

    // 4-channel instance: constant inputs, levels and duty
    check("ch4_level", 32'(level_out4), 32'({7'd127, 7'd32, 7'd32, 7'd0}));
    repeat (300) @(negedge clk);
    measure(256);
    check("ch4_duty0", 32'(hi4[0]), 32'd0);
    check("ch4_duty1", 32'(hi4[1]), 32'd64);
    check("ch4_duty2", 32'(hi4[2]), 32'd64);
    check("ch4_duty3", 32'(hi4[3]), 32'd254);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
